// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with saturating direction counters: zero-latency lookup from the IF PC,
// training and mispredict/redirect generation from the branch-resolution stage.
module branch_predict_unit #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 8,
  parameter int CNT_BITS = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_pred_taken_i,
  input  logic [XLEN-1:0] upd_pred_target_i,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispred_o
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((2 ** (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(2 ** (CNT_BITS - 1));

  logic                valid_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]     tgt_q   [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q   [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                lk_hit, up_hit, up_en;

  assign lk_idx = if_pc_i[IDX_BITS+1:2];
  assign lk_tag = if_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign up_idx = upd_pc_i[IDX_BITS+1:2];
  assign up_tag = upd_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Lookup reads only registered state, so a same-cycle update is not bypassed.
  assign lk_hit        = start_i & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign pred_hit_o    = lk_hit;
  assign pred_taken_o  = lk_hit & cnt_q[lk_idx][CNT_BITS-1];
  assign pred_target_o = lk_hit ? tgt_q[lk_idx] : '0;

  assign up_en  = upd_valid_i & start_i;
  assign up_hit = valid_q[up_idx] & (tag_q[up_idx] == up_tag);

  assign mispredict_o  = up_en & ((upd_taken_i != upd_pred_taken_i) |
                         (upd_taken_i & upd_pred_taken_i & (upd_target_i != upd_pred_target_i)));
  assign redirect_pc_o = !mispredict_o ? '0 :
                         upd_taken_i   ? upd_target_i : upd_pc_i + XLEN'(4);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= CNT_WNT;
      end
      stat_branches_o <= '0;
      stat_mispred_o  <= '0;
    end else if (up_en) begin
      if (up_hit) begin
        if (upd_taken_i) begin
          tgt_q[up_idx] <= upd_target_i;
          if (cnt_q[up_idx] != CNT_MAX) cnt_q[up_idx] <= cnt_q[up_idx] + 1'b1;
        end else if (cnt_q[up_idx] != '0) begin
          cnt_q[up_idx] <= cnt_q[up_idx] - 1'b1;
        end
      end else if (upd_taken_i) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= upd_target_i;
        cnt_q[up_idx]   <= CNT_WT;
      end
      if (stat_branches_o != 32'hFFFF_FFFF) stat_branches_o <= stat_branches_o + 32'd1;
      if (mispredict_o && stat_mispred_o != 32'hFFFF_FFFF) stat_mispred_o <= stat_mispred_o + 32'd1;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc_i[1:0], if_pc_i[XLEN-1:IDX_BITS+TAG_BITS+2]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomised + directed bench for branch_predict_unit, checked against a behavioural BTB model.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst, start, upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] if_pc, upd_pc, upd_target, upd_pred_target;
  logic        pred_hit, pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc, stat_br, stat_mp;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .if_pc_i(if_pc),
    .pred_hit_o(pred_hit), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .mispredict_o(mispredict),
    .redirect_pc_o(redirect_pc), .stat_branches_o(stat_br), .stat_mispred_o(stat_mp)
  );

  typedef struct {
    bit          v;
    int unsigned tag;
    logic [31:0] tgt;
    int          cnt;
  } ent_t;

  typedef struct {
    int          cyc;
    bit          hit, taken, misp;
    logic [31:0] target, redirect, br, mp;
  } exp_t;

  ent_t        m [16];
  longint      m_br, m_mp;
  exp_t        sbq [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m[i].v = 0; m[i].tag = 0; m[i].tgt = 0; m[i].cnt = 1;
    end
    m_br = 0; m_mp = 0;
  endtask

  // One clock of stimulus: drive, predict outputs from the model, then advance the model.
  task automatic step(input bit r, input bit st, input logic [31:0] ipc,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
    exp_t e;
    int   li, ui;
    bit   acc, uhit;
    @(posedge clk);
    #1;
    rst = r; start = st; if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    cyc++;
    li = (ipc >> 2) % 16;
    e.cyc    = cyc;
    e.hit    = st && m[li].v && m[li].tag == (ipc >> 6) % 256;
    e.taken  = e.hit && m[li].cnt >= 2;
    e.target = e.hit ? m[li].tgt : 32'd0;
    acc      = uv && st;
    e.misp   = acc && (ut != upt || (ut && upt && utgt != uptgt));
    e.redirect = !e.misp ? 32'd0 : ut ? utgt : upc + 32'd4;
    e.br = m_br[31:0];
    e.mp = m_mp[31:0];
    sbq.push_back(e);
    if (r) m_reset();
    else if (acc) begin
      ui   = (upc >> 2) % 16;
      uhit = m[ui].v && m[ui].tag == (upc >> 6) % 256;
      if (uhit) begin
        m[ui].cnt = ut ? ((m[ui].cnt < 3) ? m[ui].cnt + 1 : 3) : ((m[ui].cnt > 0) ? m[ui].cnt - 1 : 0);
        if (ut) m[ui].tgt = utgt;
      end else if (ut) begin
        m[ui].v = 1; m[ui].tag = (upc >> 6) % 256; m[ui].tgt = utgt; m[ui].cnt = 2;
      end
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (e.misp && m_mp < 64'hFFFF_FFFF) m_mp++;
    end
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, c, act, req);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle and compared with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("pred_hit",    e.cyc, {31'd0, pred_hit},   {31'd0, e.hit});
        chk("pred_taken",  e.cyc, {31'd0, pred_taken}, {31'd0, e.taken});
        chk("pred_target", e.cyc, pred_target,         e.target);
        chk("mispredict",  e.cyc, {31'd0, mispredict}, {31'd0, e.misp});
        chk("redirect_pc", e.cyc, redirect_pc,         e.redirect);
        chk("stat_br",     e.cyc, stat_br,             e.br);
        chk("stat_mp",     e.cyc, stat_mp,             e.mp);
      end
    end
  end

  // Lookup-only cycle (no update).
  task automatic look(input logic [31:0] ipc);
    step(0, 1, ipc, 0, 0, 0, 0, 0, 0);
  endtask

  // Training cycle; the predicted fields match the actual ones, so no mispredict.
  task automatic train(input logic [31:0] ipc, input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
    step(0, 1, ipc, 1, upc, ut, utgt, ut, utgt);
  endtask

  initial begin
    logic [31:0] pc, tg, ptg;
    int          wait_cnt;
    rst = 1; start = 0; if_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
    m_reset();
    @(posedge clk);
    step(1, 1, 32'h10, 0, 0, 0, 0, 0, 0);
    look(32'h10);
    // Train 0x10: allocate, saturate up, then walk down to 0.
    train(32'h10, 32'h10, 1, 32'h40);
    look(32'h10);
    train(32'h10, 32'h10, 1, 32'h40);
    train(32'h10, 32'h10, 1, 32'h40);
    for (int i = 0; i < 3; i++) train(32'h10, 32'h10, 0, 32'h0);
    look(32'h10);
    // Aliasing on index 4.
    look(32'h50);
    train(32'h10, 32'h50, 0, 32'h0);
    train(32'h10, 32'h50, 1, 32'h90);
    look(32'h50);
    look(32'h10);
    // Same-cycle lookup/update of an entry at counter 2.
    train(32'h10, 32'h10, 1, 32'h44);
    train(32'h10, 32'h10, 0, 32'h0);
    look(32'h10);
    // Mispredicts and a correct prediction.
    step(0, 1, 32'h20, 1, 32'h20, 1, 32'h80, 0, 32'h0);
    step(0, 1, 32'h20, 1, 32'h20, 0, 32'h0,  1, 32'h80);
    step(0, 1, 32'h20, 1, 32'h20, 1, 32'h80, 1, 32'h84);
    step(0, 1, 32'h20, 1, 32'h20, 1, 32'h80, 1, 32'h80);
    look(32'h20);
    // Stopped core, then reset mid-training.
    step(0, 0, 32'h20, 1, 32'h20, 1, 32'h100, 0, 32'h0);
    look(32'h20);
    step(1, 1, 32'h20, 1, 32'h20, 1, 32'h100, 0, 32'h0);
    look(32'h20);
    look(32'h10);
    // Random traffic over a small PC pool so entries alias and saturate.
    for (int n = 0; n < 600; n++) begin
      pc  = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2);
      tg  = $urandom & 32'hFFFF_FFFC;
      ptg = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : tg;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2),
           $urandom_range(0, 3) != 0, pc, $urandom_range(0, 1), tg, $urandom_range(0, 1), ptg);
    end
    step(0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h8);
    look(32'h0);
    wait_cnt = 0;
    while (sbq.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
